// File: rtl/bsg_nand_operand_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsg_nand_operand_collector_pkg
// Brief    : Shared types and constants for the NAND operand collector.
// Revision : 1.0 - initial release
// ============================================================================
package bsg_nand_operand_collector_pkg;

    // Width of the optional consumed-pair counter.
    localparam int unsigned c_PAIR_COUNT_WIDTH = 32;

    // Collector occupancy: nothing, a lone A, a full pair, a full pair plus the next A.
    typedef enum logic [1:0] {
        EMPTY       = 2'd0,
        HAVE_A      = 2'd1,
        FULL        = 2'd2,
        FULL_HAVE_A = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bsg_dff_reset_en.sv
`default_nettype none
// ============================================================================
// Module   : bsg_dff_reset_en
// Brief    : Load-enabled register with synchronous active-low clear to zero.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_dff_reset_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    // Clear on reset, otherwise capture data_i whenever enabled.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/bsg_nand_operand_collector.sv
`default_nettype none
// ============================================================================
// Module   : bsg_nand_operand_collector
// Brief    : Gathers an alternating A/B beat stream into registered operand
//            pairs for a downstream bsg_nand. Holds one full pair plus one
//            pending A beat so the stream sustains one pair every two cycles.
// Options  : BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN adds pair_count_o, a
//            wrapping count of pairs taken by the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_nand_operand_collector
    import bsg_nand_operand_collector_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [width_p-1:0]            data_i,
    input  logic                          v_i,
    output logic                          ready_o,
    output logic [width_p-1:0]            a_o,
    output logic [width_p-1:0]            b_o,
    output logic                          v_o,
    input  logic                          yumi_i
`ifdef BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN
   ,output logic [c_PAIR_COUNT_WIDTH-1:0] pair_count_o
`endif
);

    state_e               state_q;
    state_e               state_d;
    logic                 w_xfer;
    logic                 w_yumi;
    logic                 w_ld_stage;
    logic                 w_ld_out;
    logic [width_p-1:0]   stage_a_q;

    // Accepting is blocked only while a pair and the next A are both held;
    // reset also masks it so no beat appears accepted during reset.
    assign ready_o = reset_n_i & (state_q != FULL_HAVE_A);
    assign v_o     = (state_q == FULL) | (state_q == FULL_HAVE_A);
    assign w_xfer  = v_i & ready_o;
    assign w_yumi  = yumi_i & v_o;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register-load decode.
    always_comb begin
        state_d    = state_q;
        w_ld_stage = 1'b0;
        w_ld_out   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (w_xfer) begin
                    w_ld_stage = 1'b1;
                    state_d    = HAVE_A;
                end
            end
            HAVE_A: begin
                if (w_xfer) begin
                    w_ld_out = 1'b1;
                    state_d  = FULL;
                end
            end
            FULL: begin
                if (w_xfer) begin
                    w_ld_stage = 1'b1;
                    state_d    = w_yumi ? HAVE_A : FULL_HAVE_A;
                end else if (w_yumi) begin
                    state_d = EMPTY;
                end
            end
            FULL_HAVE_A: begin
                if (w_yumi) begin
                    state_d = HAVE_A;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Pending A operand.
    bsg_dff_reset_en #(.WIDTH(width_p)) u_stage_a_reg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (w_ld_stage),
        .data_i    (data_i),
        .data_o    (stage_a_q)
    );

    // Output pair registers, both written together when the B beat lands.
    bsg_dff_reset_en #(.WIDTH(width_p)) u_a_reg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (w_ld_out),
        .data_i    (stage_a_q),
        .data_o    (a_o)
    );

    bsg_dff_reset_en #(.WIDTH(width_p)) u_b_reg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (w_ld_out),
        .data_i    (data_i),
        .data_o    (b_o)
    );

`ifdef BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN
    // Consumed-pair counter; natural binary overflow gives the wrap to zero.
    bsg_dff_reset_en #(.WIDTH(c_PAIR_COUNT_WIDTH)) u_pair_count (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (w_yumi),
        .data_i    (pair_count_o + c_PAIR_COUNT_WIDTH'(1)),
        .data_o    (pair_count_o)
    );
`endif

`ifndef SYNTHESIS
    // The consumer may only take a pair that is being offered.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_o))
                else $error("yumi_i asserted while v_o is low");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_nand_operand_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_nand_operand_collector
// Brief    : Self-checking bench for bsg_nand_operand_collector with a
//            queue-based occupancy/pairing reference model.
// Options  : BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN enables the counter test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_nand_operand_collector;

    localparam int W = 64;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          v_i = 1'b0;
    logic          ready_o;
    logic [W-1:0]  a_o;
    logic [W-1:0]  b_o;
    logic          v_o;
    logic          yumi_i = 1'b0;
`ifdef BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN
    logic [31:0]   pair_count_o;
`endif

    bsg_nand_operand_collector #(.width_p(W)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (data_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .a_o       (a_o),
        .b_o       (b_o),
        .v_o       (v_o),
        .yumi_i    (yumi_i)
`ifdef BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN
       ,.pair_count_o (pair_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Counters and bookkeeping
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    bit            chk_en = 1'b0;
    int            vmode = 0;   // 0 idle, 1 always offer, 2 random offer
    int            ymode = 0;   // 0 never take, 1 always take, 2 random take

    // Reference model: beats still to send, one pending A, and complete pairs held.
    logic [W-1:0]   src_q[$];
    logic [2*W-1:0] pq[$];
    logic [W-1:0]   pend_a;
    bit             have_a = 1'b0;

    // Pairs observed being consumed at the DUT, with their cycle stamps.
    logic [2*W-1:0] got_q[$];
    int             got_t[$];

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Model update on the active edge, then drive next inputs.
    always @(posedge clk_i) begin
        logic           m_rdy;
        logic [2*W-1:0] tmp;
        cyc++;
        if (!reset_n_i) begin
            have_a = 1'b0;
            pq.delete();
        end else begin
            m_rdy = !(pq.size() > 0 && have_a);
            if (yumi_i && pq.size() > 0) tmp = pq.pop_front();
            if (v_i && m_rdy) begin
                if (src_q.size() > 0) tmp[W-1:0] = src_q.pop_front();
                if (have_a) begin
                    pq.push_back({pend_a, data_i});
                    have_a = 1'b0;
                end else begin
                    pend_a = data_i;
                    have_a = 1'b1;
                end
            end
        end
        #1;
        v_i    = (src_q.size() > 0) && (vmode == 1 || (vmode == 2 && ($urandom % 2) == 1));
        data_i = v_i ? src_q[0] : {$urandom, $urandom};
        yumi_i = (pq.size() > 0) && (ymode == 1 || (ymode == 2 && ($urandom % 2) == 1));
    end

    // Per-cycle compare of DUT against the model, plus consumption log.
    always @(negedge clk_i) begin
        logic exp_rdy;
        logic exp_v;
        if (chk_en) begin
            exp_rdy = reset_n_i && !(pq.size() > 0 && have_a);
            exp_v   = pq.size() > 0;
            chk("ready_o", {127'd0, ready_o}, {127'd0, exp_rdy});
            chk("v_o", {127'd0, v_o}, {127'd0, exp_v});
            if (exp_v) chk("pair", {a_o, b_o}, pq[0]);
            if (yumi_i && !v_o) timeout_fail("yumi_without_v_o");
            if (yumi_i && v_o) begin
                got_q.push_back({a_o, b_o});
                got_t.push_back(cyc);
            end
        end
    end

    task automatic wait_src_le(input int k, input int max, input string nm);
        int n = 0;
        while (src_q.size() > k && n < max) begin
            @(negedge clk_i);
            n++;
        end
        if (src_q.size() > k) timeout_fail(nm);
    endtask

    task automatic wait_got(input int k, input int max, input string nm);
        int n = 0;
        while (got_q.size() < k && n < max) begin
            @(negedge clk_i);
            n++;
        end
        if (got_q.size() < k) timeout_fail(nm);
    endtask

    initial begin
        int c0;
        int maxgap;
        int span;

        // Reset state
        @(posedge clk_i);
        @(negedge clk_i);
        chk_en = 1'b1;
        chk("rst_ready", {127'd0, ready_o}, 128'd0);
        chk("rst_v", {127'd0, v_o}, 128'd0);
        chk("rst_a", {64'd0, a_o}, 128'd0);
        chk("rst_b", {64'd0, b_o}, 128'd0);
`ifdef BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN
        chk("rst_count", {96'd0, pair_count_o}, 128'd0);
`endif
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        @(negedge clk_i);
        chk("ready_after_reset", {127'd0, ready_o}, 128'd1);

        // Test 1: single pair and downstream NAND
        got_q.delete(); got_t.delete();
        src_q.push_back(64'hAAAA_0000_0000_0001);
        src_q.push_back(64'h0000_0000_0000_0003);
        vmode = 1; ymode = 1;
        wait_src_le(0, 50, "t1_send");
        chk("t1_v_latency", {127'd0, v_o}, 128'd1);
        chk("t1_a", {64'd0, a_o}, {64'd0, 64'hAAAA_0000_0000_0001});
        chk("t1_b", {64'd0, b_o}, {64'd0, 64'h0000_0000_0000_0003});
        chk("t1_nand", {64'd0, ~(a_o & b_o)}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFE});
        wait_got(1, 50, "t1_consume");

        // Test 2: back-pressure with yumi held low
        repeat (3) @(negedge clk_i);
        got_q.delete(); got_t.delete();
        ymode = 0;
        for (int i = 1; i <= 8; i++) src_q.push_back(64'(i));
        wait_src_le(5, 50, "t2_three_beats");
        chk("t2_ready_blocked", {127'd0, ready_o}, 128'd0);
        chk("t2_v_held", {127'd0, v_o}, 128'd1);
        repeat (3) @(negedge clk_i);
        chk("t2_src_stalled", 128'(src_q.size()), 128'd5);
        ymode = 1;
        wait_got(4, 100, "t2_drain");
        for (int i = 0; i < 4; i++)
            chk("t2_pair_order", got_q[i], {64'(2*i+1), 64'(2*i+2)});

        // Test 3: sustained throughput
        repeat (3) @(negedge clk_i);
        got_q.delete(); got_t.delete();
        c0 = cyc;
        for (int i = 0; i < 100; i++) src_q.push_back(64'(100 + i));
        wait_got(50, 300, "t3_drain");
        if (got_q.size() >= 50) begin
            maxgap = 0;
            for (int i = 1; i < 50; i++)
                if (got_t[i] - got_t[i-1] > maxgap) maxgap = got_t[i] - got_t[i-1];
            span = got_t[49] - c0 - 1;
            chk("t3_span_ok", {127'd0, (span >= 98 && span <= 102)}, 128'd1);
            chk("t3_max_gap", 128'(maxgap), 128'd2);
            chk("t3_last_pair", got_q[49], {64'd198, 64'd199});
        end

        // Test 4: reset while holding a lone A
        repeat (3) @(negedge clk_i);
        got_q.delete(); got_t.delete();
        src_q.push_back(64'h5);
        wait_src_le(0, 50, "t4_send_a");
        @(posedge clk_i);
        #1 reset_n_i = 1'b0;
        @(negedge clk_i);
        chk("t4_ready_in_reset", {127'd0, ready_o}, 128'd0);
        @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        @(negedge clk_i);
        chk("t4_ready_after", {127'd0, ready_o}, 128'd1);
        chk("t4_v_after", {127'd0, v_o}, 128'd0);
        src_q.push_back(64'h9);
        src_q.push_back(64'hC);
        wait_got(1, 50, "t4_pair");
        chk("t4_pair", got_q[0], {64'h9, 64'hC});
        repeat (3) @(negedge clk_i);
        chk("t4_single_pair", 128'(got_q.size()), 128'd1);

`ifdef BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN
        // Test 5: counter wrap
        @(negedge clk_i);
        force dut.u_pair_count.data_q = 32'hFFFF_FFFE;
        @(negedge clk_i);
        release dut.u_pair_count.data_q;
        got_q.delete(); got_t.delete();
        for (int i = 0; i < 6; i++) src_q.push_back(64'(i + 20));
        wait_got(3, 100, "t5_drain");
        repeat (2) @(negedge clk_i);
        chk("t5_count_wrap", {96'd0, pair_count_o}, 128'd1);
`endif

        // Test 6: random handshakes against the model
        repeat (3) @(negedge clk_i);
        got_q.delete(); got_t.delete();
        for (int i = 0; i < 10000; i++) src_q.push_back({$urandom, $urandom});
        vmode = 2; ymode = 2;
        wait_src_le(0, 80000, "t6_send");
        wait_got(5000, 2000, "t6_drain");
        chk("t6_pair_total", 128'(got_q.size()), 128'd5000);
        repeat (2) @(negedge clk_i);
        chk("t6_idle_v", {127'd0, v_o}, 128'd0);

        vmode = 0; ymode = 0;
        repeat (2) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_nand_operand_collector.md
BSG_NAND_OPERAND_COLLECTOR -- requirements
Module: bsg_nand_operand_collector

Interface
REQ-001 The block SHALL have parameter width_p, default 64, giving the width of each operand word.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n_i, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port data_i, input, width_p bits: operand beat from the upstream stream.
REQ-005 The block SHALL have port v_i, input, 1 bit: data_i is valid.
REQ-006 The block SHALL have port ready_o, output, 1 bit: the block accepts data_i this cycle; it is a function of registered state only.
REQ-007 The block SHALL have port a_o, output, width_p bits: first operand of the pair, driven to the downstream bsg_nand a_i.
REQ-008 The block SHALL have port b_o, output, width_p bits: second operand of the pair, driven to the downstream bsg_nand b_i.
REQ-009 The block SHALL have port v_o, output, 1 bit: a_o/b_o hold a complete pair.
REQ-010 The block SHALL have port yumi_i, input, 1 bit: the consumer takes the pair this cycle; legal only when v_o=1.

Function
REQ-011 A beat SHALL transfer when v_i & ready_o; beats alternate roles A, B, A, B... starting with A after reset.
REQ-012 The FSM SHALL have the states EMPTY, HAVE_A, FULL and FULL_HAVE_A.
REQ-013 EMPTY: on a transfer, latch data_i into stage_a_r and go to HAVE_A; otherwise stay.
REQ-014 HAVE_A: on a transfer, load a_o<=stage_a_r and b_o<=data_i, then go to FULL; otherwise stay.
REQ-015 FULL: yumi&transfer -> latch stage_a_r, go HAVE_A; yumi only -> EMPTY; transfer only -> latch stage_a_r, go FULL_HAVE_A; neither -> stay.
REQ-016 FULL_HAVE_A: ready_o=0; yumi_i -> HAVE_A; otherwise stay.
REQ-017 ready_o SHALL be 1 in EMPTY, HAVE_A and FULL, and 0 in FULL_HAVE_A and while reset_n_i=0.
REQ-018 v_o SHALL be 1 exactly in FULL and FULL_HAVE_A.
REQ-019 a_o and b_o SHALL be register outputs, stable while v_o=1 and yumi_i=0.
REQ-020 Latency SHALL be: B beat accepted in cycle n -> v_o=1 in cycle n+1.
REQ-021 Sustained throughput SHALL be one pair per two cycles when v_i=1 and yumi_i=1 whenever v_o=1.
REQ-022 Data SHALL never be dropped, duplicated or reordered, and operand pairing SHALL never slip.
REQ-023 An assertion SHALL flag yumi_i=1 while v_o=0; that condition is illegal.

Reset
REQ-024 While reset_n_i=0 at a clock edge, the state SHALL become EMPTY and stage_a_r, a_o and b_o SHALL become 0.
REQ-025 Reset mid-operation SHALL discard any partial or held pair; the next accepted beat after reset is an A beat.
REQ-026 Reset values SHALL be: v_o=0 and ready_o=0 during reset; ready_o=1 in the first cycle after reset deasserts.

Configuration
REQ-027 Macro BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN defined: the block SHALL add output pair_count_o, 32 bits, reset to 0, incremented on each v_o&yumi_i and wrapping from 0xFFFFFFFF to 0.
REQ-028 Macro BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN undefined: pair_count_o and its counter SHALL be absent, with all other behaviour identical.

Structure
REQ-029 Package bsg_nand_operand_collector_pkg SHALL hold the FSM state enum and the pair-count width constant (32).
REQ-030 Registers SHALL use bsg_dff_reset_en as the single natural sub-module; no other sub-modules.

Verification
REQ-031 Test 1: reset, then beats 0xAAAA_0000_0000_0001 and 0x0000_0000_0000_0003 with yumi_i=1 -> one cycle after B, v_o=1, a_o=0xAAAA_0000_0000_0001, b_o=0x3; downstream NAND gives 0xFFFF_FFFF_FFFF_FFFE.
REQ-032 Test 2: stream 8 beats (values 1..8) with v_i=1 and yumi_i=0 -> after beats 1-3, ready_o=0 and state=FULL_HAVE_A; releasing yumi_i yields pairs (1,2),(3,4),(5,6),(7,8) in order.
REQ-033 Test 3: continuous v_i and yumi_i over 100 beats -> 50 pairs in 100±2 cycles, no gaps beyond one cycle.
REQ-034 Test 4: reset_n_i=0 for one cycle in HAVE_A after A=0x5 -> next beats 0x9, 0xC pair as (0x9,0xC); 0x5 is never output.
REQ-035 Test 5: with BSG_NAND_OPERAND_COLLECTOR_PAIR_COUNT_EN, preload the counter to 0xFFFFFFFE and consume 3 pairs -> pair_count_o=0x00000001.
REQ-036 Test 6: random v_i/yumi_i at 50%, 10k beats -> a scoreboard matches every pair and the yumi_i-without-v_o assertion never fires.
